// File: rtl/uart_rx.sv
// uart_rx: 8-bit serial receiver (start, 8 data LSB-first, optional extra bit, stop) behind a 2-flop synchronizer.
// Latency: valid pulses HALF_BIT + 10*CLKS_PER_BIT + 1 cycles after START entry; no backpressure, each byte is a single-cycle strobe.
// Optional UART_RX_EXTRA_CHECK_EN: a 1 in the extra bit rejects the frame with frame_err.
module uart_rx #(
    parameter int CLKS_PER_BIT = 5208,
    parameter int HALF_BIT     = 2604,
    parameter int CNT_W        = 13,
    parameter int EXTRA_BIT    = 1
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       uart_rxd,
    output logic [7:0] dout,
    output logic       valid,
    output logic       frame_err,
    output logic       busy
);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_EXTRA, S_STOP, S_WAIT_HIGH
    } state_t;

    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(HALF_BIT - 1);
    localparam logic [CNT_W-1:0] BIT_M1  = CNT_W'(CLKS_PER_BIT - 1);

    state_t           state, state_nxt;
    logic             rxd_m, rxd_s;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shift;
    logic             sample;
    logic             extra_err;
    logic             valid_nxt, ferr_nxt;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            rxd_m <= 1'b1;
            rxd_s <= 1'b1;
        end else begin
            rxd_m <= uart_rxd;
            rxd_s <= rxd_m;
        end
    end

`ifdef UART_RX_EXTRA_CHECK_EN
    // Sticky until the frame ends; the stop sample turns it into frame_err.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst)
            extra_err <= 1'b0;
        else if (state == S_IDLE)
            extra_err <= 1'b0;
        else if (state == S_EXTRA && sample && rxd_s)
            extra_err <= 1'b1;
    end
`else
    assign extra_err = 1'b0;
`endif

    always_comb begin
        sample = 1'b0;
        case (state)
            S_START:                 sample = (cnt == HALF_M1);
            S_DATA, S_EXTRA, S_STOP: sample = (cnt == BIT_M1);
            default:                 sample = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:      if (!rxd_s) state_nxt = S_START;
            S_START:     if (sample) state_nxt = rxd_s ? S_IDLE : S_DATA;
            S_DATA:      if (sample && bit_idx == 3'd7)
                             state_nxt = (EXTRA_BIT != 0) ? S_EXTRA : S_STOP;
            S_EXTRA:     if (sample) state_nxt = S_STOP;
            // Leaving at mid-stop-bit leaves half a bit to catch a back-to-back start edge.
            S_STOP:      if (sample) state_nxt = rxd_s ? S_IDLE : S_WAIT_HIGH;
            S_WAIT_HIGH: if (rxd_s) state_nxt = S_IDLE;
            default:     state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        busy      = (state != S_IDLE);
        valid_nxt = (state == S_STOP) && sample && rxd_s && !extra_err;
        ferr_nxt  = (state == S_STOP) && sample && !(rxd_s && !extra_err);
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            cnt       <= '0;
            bit_idx   <= 3'd0;
            shift     <= 8'h00;
            dout      <= 8'h00;
            valid     <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            valid     <= valid_nxt;
            frame_err <= ferr_nxt;
            if (state_nxt != state || sample)
                cnt <= '0;
            else if (state != S_IDLE && state != S_WAIT_HIGH)
                cnt <= cnt + CNT_W'(1);
            if (state == S_START && sample)
                bit_idx <= 3'd0;
            else if (state == S_DATA && sample) begin
                bit_idx <= bit_idx + 3'd1;
                shift   <= {rxd_s, shift[7:1]};
            end
            if (valid_nxt)
                dout <= shift;
        end
    end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Serial receiver for the UART link, 50 MHz system clock, 9,600 baud by default.
- Consumes the frame format our transmitter produces: start bit (0), 8 data bits LSB-first, one extra bit (driven 0 by the transmitter), stop bit (1).
- Recovers bytes from the serial line and presents each one with a single-cycle valid strobe to the downstream logic.
- Used both for the external RX pin and for transmitter loopback tests.

Parameters:
- CLKS_PER_BIT, 5208: clock cycles per bit period (50 MHz / 9,600). Minimum 4.
- HALF_BIT, 2604: cycles from start-edge detection to the start-bit check. Must equal CLKS_PER_BIT/2.
- CNT_W, 13: width of the bit-period counter. Must satisfy 2^CNT_W > CLKS_PER_BIT.
- EXTRA_BIT, 1: 1 = frame carries the extra bit between data and stop; 0 = no extra bit.

Ports:
- clk, input, 1: system clock, 50 MHz.
- n_rst, input, 1: asynchronous, active-low reset.
- uart_rxd, input, 1: raw serial line. Idles high. Asynchronous to clk.
- dout, output, 8: last correctly received byte. Holds its value until the next good frame.
- valid, output, 1: one-cycle pulse; dout is new in the same cycle.
- frame_err, output, 1: one-cycle pulse when a frame is rejected.
- busy, output, 1: high in every state except IDLE.

Behaviour:
- Reset values (n_rst low, asynchronous): dout = 8'h00; valid = 0; frame_err = 0; busy = 0; state = IDLE; synchronizer flops = 1; counters = 0.
- Synchronizer: uart_rxd passes through 2 flops to give rxd_s. All decisions use rxd_s only.
- Counters:
  - cnt (CNT_W bits) increments every cycle outside IDLE and WAIT_HIGH.
  - cnt clears to 0 on every sample point and on every state change.
  - bit_idx (3 bits) counts data bits 0..7.
- IDLE:
  - rxd_s == 0 → START; cnt <= 0.
  - Otherwise stay in IDLE.
- START:
  - Sample point: the edge with cnt == HALF_BIT-1 (HALF_BIT cycles after entry).
  - rxd_s == 0 → DATA, bit_idx <= 0.
  - rxd_s == 1 → false start: return to IDLE. No output pulse.
- DATA:
  - Sample point: the edge with cnt == CLKS_PER_BIT-1.
  - Shift register <= {rxd_s, shift[7:1]}.
  - bit_idx == 7 at the sample point → EXTRA if EXTRA_BIT == 1, else STOP.
- EXTRA:
  - Samples at cnt == CLKS_PER_BIT-1, then → STOP.
  - The sampled value is handled per the Optional Feature.
- STOP:
  - Samples at cnt == CLKS_PER_BIT-1.
  - rxd_s == 1 and no pending error: dout <= shift; valid = 1 for one cycle; → IDLE. Returning to IDLE at mid-stop-bit supports back-to-back frames.
  - rxd_s == 0 (break or framing error): frame_err = 1 for one cycle; dout unchanged; → WAIT_HIGH.
- WAIT_HIGH:
  - Stays until rxd_s == 1, then → IDLE.
  - A held-low line never produces repeated frames.
- Latency (EXTRA_BIT = 1):
  - valid is high in the cycle after the edge that is HALF_BIT + 10·CLKS_PER_BIT cycles after START entry.
  - START entry is 2–3 cycles after the raw falling edge (synchronizer).
- valid and frame_err are never high in the same cycle.
- busy = 1 in START, DATA, EXTRA, STOP and WAIT_HIGH.
- Reset asserted mid-frame: immediate return to the reset values. The partial byte is discarded; no pulse is generated.

Optional Feature:
- Macro: UART_RX_EXTRA_CHECK_EN.
- Defined (only meaningful with EXTRA_BIT == 1):
  - The extra bit must be 0.
  - If it samples 1, an error flag is set. At the stop sample this gives frame_err instead of valid, and dout is unchanged.
  - A good stop bit then → IDLE; a bad stop bit → WAIT_HIGH.
- Undefined: the extra bit is sampled and ignored. No flag logic is synthesized.

Test Plan:
- Use CLKS_PER_BIT = 16, HALF_BIT = 8, CNT_W = 5 in all scenarios.
- Scenario 1: drive frame 0xA5 (line 0,1,0,1,0,0,1,0,1,0,1, each bit 16 cycles) → exactly one valid pulse; dout = 8'hA5; frame_err stays 0; busy returns to 0.
- Scenario 2: send 0x00 then 0xFF back-to-back, no idle gap → two valid pulses, dout = 8'h00 then 8'hFF.
- Scenario 3: 4-cycle low glitch on an idle line → busy high for about 8 cycles, then 0; no valid, no frame_err; dout unchanged.
- Scenario 4: frame 0x3C with the stop bit forced 0, then the line held low 100 cycles → one frame_err pulse; no valid; dout keeps its previous value; busy stays high until the line goes high.
- Scenario 5: assert n_rst low at data bit 4 of a frame → all outputs at reset values immediately. A following clean frame 0x5A gives valid with dout = 8'h5A.
- Scenario 6: with UART_RX_EXTRA_CHECK_EN defined, frame 0x81 with extra bit = 1 → frame_err, no valid. Without the macro, the same stimulus → valid with dout = 8'h81.
